// File: rtl/vga_sync_rx.sv
// vga_sync_rx: recovers raster position, display-enable and lock from a VGA hsync/vsync pair.
// Define VGA_RX_MEASURE_EN to enable line/frame period measurement on h_period/v_period.
module vga_sync_rx #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_TOTAL    = 800,
  parameter int V_VISIBLE  = 480,
  parameter int V_FP       = 10,
  parameter int V_TOTAL    = 525,
  parameter int LOCK_LINES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hsync,
  input  logic        vsync,
  output logic [9:0]  px,
  output logic [9:0]  py,
  output logic        de,
  output logic        locked,
  output logic        frame_start,
  output logic        timing_err,
  output logic [11:0] h_period,
  output logic [11:0] v_period
);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_HLOCK  = 2'd1,
    ST_VWAIT  = 2'd2,
    ST_LOCKED = 2'd3
  } state_t;

  localparam logic [9:0] HS      = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_NEXT = 10'(H_VISIBLE + H_FP + 1);
  localparam logic [9:0] VS      = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS   = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS   = 10'(V_VISIBLE);
  localparam int         GW      = $clog2(LOCK_LINES + 1);
  localparam logic [GW-1:0] GOOD_ZERO = GW'(0);
  localparam logic [GW-1:0] GOOD_ONE  = GW'(1);
  localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_LINES - 1);
  // A geometry whose sync pulse or porches do not fit the line/frame can never be trusted.
  localparam logic CFG_OK = ((H_VISIBLE + H_FP + H_SYNC < H_TOTAL) &&
                             (V_VISIBLE + V_FP < V_TOTAL) &&
                             (H_TOTAL <= 1024) && (V_TOTAL <= 1024) &&
                             (LOCK_LINES > 0)) ? 1'b1 : 1'b0;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_hsync_q;
  logic          r_vsync_q;
  logic [9:0]    r_hcnt;
  logic [9:0]    r_vcnt;
  logic [9:0]    w_hcnt_nxt;
  logic [9:0]    w_vcnt_nxt;
  logic [9:0]    w_hcnt_run;
  logic [9:0]    w_vcnt_run;
  logic [GW-1:0] r_good;
  logic [GW-1:0] w_good_nxt;
  logic          r_timing_err;
  logic          w_err_nxt;
  logic          w_hfall;
  logic          w_vfall;
  logic          w_at_hs;
  logic          w_at_vs;
  logic          w_h_ok;
  logic          w_h_bad;
  logic          w_v_bad;

  assign w_hfall = r_hsync_q & ~hsync;
  assign w_vfall = r_vsync_q & ~vsync;
  assign w_at_hs = (r_hcnt == HS);
  assign w_at_vs = (r_hcnt == 10'd0) && (r_vcnt == VS);
  assign w_h_ok  = w_hfall & w_at_hs;
  assign w_h_bad = w_hfall ^ w_at_hs;
  assign w_v_bad = w_vfall ^ w_at_vs;

  // Free-running raster position before any resynchronising load.
  always_comb begin
    w_hcnt_run = r_hcnt + 10'd1;
    w_vcnt_run = r_vcnt;
    if (r_hcnt == H_LAST) begin
      w_hcnt_run = 10'd0;
      if (r_vcnt == V_LAST) begin
        w_vcnt_run = 10'd0;
      end else begin
        w_vcnt_run = r_vcnt + 10'd1;
      end
    end else begin
      w_hcnt_run = r_hcnt + 10'd1;
    end
  end

  // Lock FSM next-state, counter loads and violation detection.
  always_comb begin
    w_state_nxt = r_state;
    w_good_nxt  = r_good;
    w_hcnt_nxt  = w_hcnt_run;
    w_vcnt_nxt  = w_vcnt_run;
    w_err_nxt   = 1'b0;
    case (r_state)
      ST_SEARCH: begin
        if (w_hfall) begin
          w_state_nxt = ST_HLOCK;
          w_good_nxt  = GOOD_ZERO;
          w_hcnt_nxt  = HS_NEXT;
        end else begin
          w_state_nxt = ST_SEARCH;
        end
      end
      ST_HLOCK: begin
        if (w_hfall) begin
          w_hcnt_nxt = HS_NEXT;
        end else begin
          w_hcnt_nxt = w_hcnt_run;
        end
        if (w_h_bad) begin
          w_good_nxt = GOOD_ZERO;
        end else if (w_h_ok) begin
          w_good_nxt = r_good + GOOD_ONE;
          if (r_good == GOOD_LAST) begin
            w_state_nxt = ST_VWAIT;
          end else begin
            w_state_nxt = ST_HLOCK;
          end
        end else begin
          w_good_nxt = r_good;
        end
      end
      ST_VWAIT: begin
        // The vsync edge pins both axes; it marks sample (0, VS).
        if (w_vfall) begin
          w_vcnt_nxt = VS;
          w_hcnt_nxt = 10'd1;
        end else if (w_hfall) begin
          w_hcnt_nxt = HS_NEXT;
        end else begin
          w_hcnt_nxt = w_hcnt_run;
        end
        if (w_h_bad) begin
          w_state_nxt = ST_HLOCK;
          w_good_nxt  = GOOD_ZERO;
        end else if (w_vfall && CFG_OK) begin
          w_state_nxt = ST_LOCKED;
        end else begin
          w_state_nxt = ST_VWAIT;
        end
      end
      ST_LOCKED: begin
        if (w_h_bad || w_v_bad) begin
          w_state_nxt = ST_SEARCH;
          w_good_nxt  = GOOD_ZERO;
          w_err_nxt   = 1'b1;
        end else begin
          w_state_nxt = ST_LOCKED;
        end
      end
      default: begin
        w_state_nxt = ST_SEARCH;
        w_good_nxt  = GOOD_ZERO;
      end
    endcase
  end

  // State, raster counters, sync history and the error pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_SEARCH;
      r_good       <= GOOD_ZERO;
      r_hcnt       <= 10'd0;
      r_vcnt       <= 10'd0;
      r_hsync_q    <= 1'b1;
      r_vsync_q    <= 1'b1;
      r_timing_err <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_good       <= w_good_nxt;
      r_hcnt       <= w_hcnt_nxt;
      r_vcnt       <= w_vcnt_nxt;
      r_hsync_q    <= hsync;
      r_vsync_q    <= vsync;
      r_timing_err <= w_err_nxt;
    end
  end

`ifdef VGA_RX_MEASURE_EN
  logic [11:0] r_hcyc;
  logic [11:0] r_vlines;
  logic [11:0] r_h_period;
  logic [11:0] r_v_period;

  function automatic logic [11:0] sat_inc(input logic [11:0] v);
    return (v == 12'hFFF) ? v : v + 12'd1;
  endfunction

  // Cycles between hsync edges and hsync edges between vsync edges, sampled on each edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hcyc     <= 12'd0;
      r_vlines   <= 12'd0;
      r_h_period <= 12'd0;
      r_v_period <= 12'd0;
    end else begin
      if (w_hfall) begin
        r_h_period <= r_hcyc;
        r_hcyc     <= 12'd1;
      end else begin
        r_hcyc     <= sat_inc(r_hcyc);
      end
      if (w_vfall) begin
        r_v_period <= w_hfall ? sat_inc(r_vlines) : r_vlines;
        r_vlines   <= w_hfall ? 12'd1 : 12'd0;
      end else if (w_hfall) begin
        r_vlines   <= sat_inc(r_vlines);
      end else begin
        r_vlines   <= r_vlines;
      end
    end
  end

  assign h_period = r_h_period;
  assign v_period = r_v_period;
`else
  assign h_period = 12'd0;
  assign v_period = 12'd0;
`endif

  assign px          = r_hcnt;
  assign py          = r_vcnt;
  assign locked      = (r_state == ST_LOCKED);
  assign de          = locked && (r_hcnt < H_VIS) && (r_vcnt < V_VIS);
  assign frame_start = locked && (r_hcnt == 10'd0) && (r_vcnt == 10'd0);
  assign timing_err  = r_timing_err;

endmodule

// File: tb/tb_vga_sync_rx.sv
// Self-checking bench for vga_sync_rx on a reduced 16x12 in 32x20 raster driven by a sync source model.
module tb_vga_sync_rx;

  localparam int HV = 16, HF = 4, HSY = 4, HT = 32;
  localparam int VV = 12, VF = 2, VT = 20, LL = 4;
  localparam int HS = HV + HF, VS = VV + VF, VSW = 2;
  localparam int FRAME = HT * VT;
  localparam int M_NORM = 0, M_DLY = 1, M_OMIT = 2, M_QUIET = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        hsync = 1'b1;
  logic        vsync = 1'b1;
  logic [9:0]  px, py;
  logic        de, locked, frame_start, timing_err;
  logic [11:0] h_period, v_period;

  typedef struct {
    int px;
    int py;
    bit de;
    bit fs;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   sx = 0, sy = 0, cur_sx = 0, cur_sy = 0;
  bit   sb_on = 1'b0;

  always #5 clk = ~clk;

  vga_sync_rx #(
    .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HSY), .H_TOTAL(HT),
    .V_VISIBLE(VV), .V_FP(VF), .V_TOTAL(VT), .LOCK_LINES(LL)
  ) dut (
    .clk(clk), .reset(reset), .hsync(hsync), .vsync(vsync),
    .px(px), .py(py), .de(de), .locked(locked), .frame_start(frame_start),
    .timing_err(timing_err), .h_period(h_period), .v_period(v_period)
  );

  // One source cycle: drive sample (sx,sy) at negedge, queue expectation, settle mid-cycle.
  task automatic step(input int mode);
    bit   hl, vl;
    exp_t e;
    @(negedge clk);
    reset = 1'b0;
    hl = (sx >= HS) && (sx < HS + HSY);
    if (mode == M_DLY) hl = (sx >= HS + 1) && (sx < HS + HSY + 1);
    if (mode == M_OMIT) hl = 1'b0;
    vl = (sy >= VS) && (sy < VS + VSW);
    if (mode == M_QUIET) begin
      hl = 1'b0;
      vl = 1'b0;
    end
    hsync = ~hl;
    vsync = ~vl;
    cur_sx = sx;
    cur_sy = sy;
    if (sb_on) begin
      e.px = sx;
      e.py = sy;
      e.de = (sx < HV) && (sy < VV);
      e.fs = (sx == 0) && (sy == 0);
      sbq.push_back(e);
    end
    sx++;
    if (sx == HT) begin
      sx = 0;
      sy++;
      if (sy == VT) sy = 0;
    end
    #1;
  endtask

  // Holds reset across several edges; the next step() releases it with sample (0,0).
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    hsync = 1'b1;
    vsync = 1'b1;
    repeat (3) @(posedge clk);
    sx = 0;
    sy = 0;
  endtask

  task automatic run_until(input int tx, input int ty);
    for (int k = 0; k < 2 * FRAME; k++) begin
      if (sx == tx && sy == ty) break;
      step(M_NORM);
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (px !== 10'd0) begin errors++; $display("FAIL reset_px: got %0d want 0", px); end
    checks++; if (py !== 10'd0) begin errors++; $display("FAIL reset_py: got %0d want 0", py); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b want 0", locked); end
    checks++; if (de !== 1'b0) begin errors++; $display("FAIL reset_de: got %b want 0", de); end
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_fs: got %b want 0", frame_start); end
    checks++; if (timing_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", timing_err); end
    checks++; if (h_period !== 12'd0 || v_period !== 12'd0) begin
      errors++; $display("FAIL reset_period: got h=%0d v=%0d want 0 0", h_period, v_period);
    end
    step(M_NORM);
    checks++; if (px !== 10'd0 || py !== 10'd0 || locked !== 1'b0) begin
      errors++; $display("FAIL reset_first_cycle: got px=%0d py=%0d locked=%b want 0 0 0", px, py, locked);
    end
  endtask

  task automatic test_free_run_quiet();
    int errs = 0, lk = 0, mism = 0;
    do_reset();
    for (int i = 0; i < 2 * FRAME; i++) begin
      step(M_QUIET);
      if (timing_err) errs++;
      if (locked) lk++;
      if (px !== 10'(cur_sx) || py !== 10'(cur_sy)) mism++;
    end
    checks++; if (errs != 0) begin errors++; $display("FAIL quiet_err: got %0d pulses want 0", errs); end
    checks++; if (lk != 0) begin errors++; $display("FAIL quiet_locked: got %0d locked cycles want 0", lk); end
    checks++; if (mism != 0) begin errors++; $display("FAIL quiet_freerun: got %0d position mismatches want 0", mism); end
  endtask

  task automatic test_lock_acquire();
    int lock_at = -1, errs = 0, de_cnt = 0;
    do_reset();
    for (int i = 0; i < 2 * FRAME; i++) begin
      step(M_NORM);
      if (timing_err) errs++;
      if (locked) begin
        lock_at = i;
        break;
      end
      if (de || frame_start) de_cnt++;
    end
    checks++; if (lock_at != VS * HT + 1) begin
      errors++; $display("FAIL acquire_time: got cycle %0d want %0d", lock_at, VS * HT + 1);
    end
    checks++; if (errs != 0) begin errors++; $display("FAIL acquire_err: got %0d pulses want 0", errs); end
    checks++; if (de_cnt != 0) begin errors++; $display("FAIL acquire_de: got %0d de/fs cycles while unlocked want 0", de_cnt); end
  endtask

  task automatic test_steady_frame();
    exp_t e;
    int de_cnt = 0, fs_cnt = 0;
    sb_on = 1'b1;
    for (int i = 0; i < 2 * FRAME; i++) begin
      step(M_NORM);
      if (de === 1'b1) de_cnt++;
      if (frame_start === 1'b1) fs_cnt++;
      checks++;
      if (sbq.size() == 0) begin
        errors++; $display("FAIL steady_queue: got empty scoreboard want 1 entry");
      end else begin
        e = sbq.pop_front();
        if (px !== 10'(e.px) || py !== 10'(e.py) || de !== e.de || frame_start !== e.fs || locked !== 1'b1) begin
          errors++;
          $display("FAIL steady: got px=%0d py=%0d de=%b fs=%b locked=%b want px=%0d py=%0d de=%b fs=%b locked=1",
                   px, py, de, frame_start, locked, e.px, e.py, e.de, e.fs);
        end
      end
    end
    sb_on = 1'b0;
    sbq.delete();
    checks++; if (de_cnt != 2 * HV * VV) begin errors++; $display("FAIL steady_de_count: got %0d want %0d", de_cnt, 2 * HV * VV); end
    checks++; if (fs_cnt != 2) begin errors++; $display("FAIL steady_fs_count: got %0d want 2", fs_cnt); end
  endtask

  // Disturbs one line with the given source mode, then checks the error pulse and the relock point.
  task automatic disturb_line(input int mode, input int line, input string tag);
    int first_err = -1, errs = 0, rl_x = -1, rl_y = -1;
    logic lk_pre = 1'bx, lk_post = 1'bx;
    run_until(0, line);
    for (int c = 0; c < HT; c++) begin
      step(mode);
      if (cur_sx == HS) lk_pre = locked;
      if (cur_sx == HS + 1) lk_post = locked;
      if (timing_err) begin
        errs++;
        if (first_err < 0) first_err = cur_sx;
      end
    end
    checks++; if (lk_pre !== 1'b1) begin errors++; $display("FAIL %s_locked_before: got %b want 1", tag, lk_pre); end
    checks++; if (first_err != HS + 1) begin errors++; $display("FAIL %s_err_col: got %0d want %0d", tag, first_err, HS + 1); end
    checks++; if (lk_post !== 1'b0) begin errors++; $display("FAIL %s_unlock: got %b want 0", tag, lk_post); end
    for (int k = 0; k < 2 * FRAME; k++) begin
      step(M_NORM);
      if (timing_err) errs++;
      if (locked) begin
        rl_x = cur_sx;
        rl_y = cur_sy;
        break;
      end
    end
    checks++; if (rl_x != 1 || rl_y != VS) begin
      errors++; $display("FAIL %s_relock: got (%0d,%0d) want (1,%0d)", tag, rl_x, rl_y, VS);
    end
    checks++; if (errs != 1) begin errors++; $display("FAIL %s_err_count: got %0d want 1", tag, errs); end
  endtask

  task automatic test_delayed_hsync();
    disturb_line(M_DLY, 2, "delayed");
  endtask

  task automatic test_omitted_hsync();
    disturb_line(M_OMIT, 3, "omitted");
  endtask

  task automatic test_period_measure();
    int exp_h, exp_v;
`ifdef VGA_RX_MEASURE_EN
    exp_h = HT;
    exp_v = VT;
`else
    exp_h = 0;
    exp_v = 0;
`endif
    repeat (FRAME) step(M_NORM);
    checks++; if (h_period !== 12'(exp_h)) begin errors++; $display("FAIL h_period: got %0d want %0d", h_period, exp_h); end
    checks++; if (v_period !== 12'(exp_v)) begin errors++; $display("FAIL v_period: got %0d want %0d", v_period, exp_v); end
  endtask

  task automatic test_reset_midframe();
    run_until(10, 5);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL midreset_pre_locked: got %b want 1", locked); end
    // Spurious hsync edge in the reset cycle would otherwise raise timing_err.
    @(negedge clk);
    reset = 1'b1;
    hsync = 1'b0;
    vsync = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (px !== 10'd0 || py !== 10'd0) begin errors++; $display("FAIL midreset_pos: got px=%0d py=%0d want 0 0", px, py); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL midreset_locked: got %b want 0", locked); end
    checks++; if (timing_err !== 1'b0) begin errors++; $display("FAIL midreset_err: got %b want 0", timing_err); end
    checks++; if (h_period !== 12'd0) begin errors++; $display("FAIL midreset_hperiod: got %0d want 0", h_period); end
    @(negedge clk);
    hsync = 1'b1;
  endtask

  initial begin
    test_reset();
    test_free_run_quiet();
    test_lock_acquire();
    test_steady_frame();
    test_delayed_hsync();
    test_steady_frame();
    test_omitted_hsync();
    test_steady_frame();
    test_period_measure();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
